// File: rtl/delaychain_pkg.sv
// Shared types and default sizing for the delay-chain measurement sequencer.
// The localparams are the defaults picked up by delaychain_sequencer's parameters.
package delaychain_pkg;

  localparam int NCHAIN    = 8;
  localparam int CNT_W     = 16;
  localparam int FLUSH_CYC = 256;
  localparam int PULSE_LEN = 4;
  localparam int TIMEOUT   = 1023;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    LAUNCH,
    WAIT,
    DONE
  } state_e;

endpackage

// File: rtl/dc_cycle_counter.sv
// Clear / enable cycle counter that saturates at LIMIT instead of wrapping.
// Shared by the flush and launch/wait phases of the sequencer.
module dc_cycle_counter #(
  parameter int W     = 16,
  parameter int LIMIT = 1023
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         at_limit
);

  assign at_limit = (count == W'(LIMIT));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !at_limit) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/delaychain_sequencer.sv
// Flushes a selected delay chain, launches a pulse into it and counts cycles until it
// emerges; reports latency plus stuck-at-1 and timeout fault flags. All outputs registered.
module delaychain_sequencer #(
  parameter int NCHAIN    = delaychain_pkg::NCHAIN,
  parameter int CNT_W     = delaychain_pkg::CNT_W,
  parameter int FLUSH_CYC = delaychain_pkg::FLUSH_CYC,
  parameter int PULSE_LEN = delaychain_pkg::PULSE_LEN,
  parameter int TIMEOUT   = delaychain_pkg::TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [$clog2(NCHAIN)-1:0] chan,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          latency,
  output logic                      err_stuck,
  output logic                      err_timeout,
  output logic [NCHAIN-1:0]         chain_din,
  input  logic [NCHAIN-1:0]         chain_dout
);

  import delaychain_pkg::*;

  localparam int CH_W = $clog2(NCHAIN);

  state_e            state;
  logic [CH_W-1:0]   chan_q;
  logic [CNT_W-1:0]  count;
  logic              at_limit;
  logic              cnt_clr;
  logic              cnt_en;
  logic              flush_last;
  logic              launch_last;
  logic              dout_sel;

  assign dout_sel    = chain_dout[chan_q];
  assign flush_last  = (state == FLUSH)  && (count == CNT_W'(FLUSH_CYC - 1));
  assign launch_last = (state == LAUNCH) && (count == CNT_W'(PULSE_LEN - 1));

  // The counter restarts at 0 on entry to FLUSH (from IDLE) and on entry to LAUNCH,
  // so count reads 0 in the first cycle chain_din[chan] is high.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state)
      IDLE:         cnt_clr = 1'b1;
      FLUSH: begin
        cnt_clr = flush_last;
        cnt_en  = 1'b1;
      end
      LAUNCH, WAIT: cnt_en = 1'b1;
      default: ;
    endcase
  end

  dc_cycle_counter #(
    .W     (CNT_W),
    .LIMIT (TIMEOUT)
  ) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .count    (count),
    .at_limit (at_limit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      chan_q      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      latency     <= '0;
      err_stuck   <= 1'b0;
      err_timeout <= 1'b0;
      chain_din   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            chan_q      <= CH_W'(chan % NCHAIN);
            latency     <= '0;
            err_stuck   <= 1'b0;
            err_timeout <= 1'b0;
            busy        <= 1'b1;
            state       <= FLUSH;
          end
        end

        FLUSH: begin
          if (flush_last) begin
            if (dout_sel) begin
              err_stuck <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              chain_din <= NCHAIN'(1) << chan_q;
              state     <= LAUNCH;
            end
          end
        end

        // Detection takes priority over timeout and over the end of the launch pulse.
        LAUNCH, WAIT: begin
          if (dout_sel) begin
            latency   <= count;
            done      <= 1'b1;
            chain_din <= '0;
            state     <= DONE;
          end else if (at_limit) begin
            latency     <= CNT_W'(TIMEOUT);
            err_timeout <= 1'b1;
            done        <= 1'b1;
            chain_din   <= '0;
            state       <= DONE;
          end else if (launch_last) begin
            chain_din <= '0;
            state     <= WAIT;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          chain_din <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
